uart_cmd_sequencer: RTL and testbench
=====================================

Name: uart_cmd_sequencer

Overview:
- Command sequencer between the UART RX/TX FIFOs and the 0–9999 counter.
- Pops command bytes from the RX FIFO, drives the counter run/clear/mode controls, and echoes each byte into the TX FIFO.
- On a status request it converts a snapshot of the count to four ASCII decimal digits plus CR LF and pushes them to the TX FIFO.
- Merges debounced button pulses with the UART commands into single control outputs.

Parameters:
ECHO_EN, 1, 1 = push every received byte back to TX FIFO before acting on any report
CMD_RUN, 8'h64, byte ('d') that toggles run
CMD_CLR, 8'h72, byte ('r') that pulses clear
CMD_MODE, 8'h6d, byte ('m') that toggles mode
CMD_STAT, 8'h73, byte ('s') that requests a decimal count report
CNT_MAX, 9999, saturation value for reported count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
rx_empty  in  1  RX FIFO empty
rx_data  in  8  RX FIFO head byte, valid while rx_empty=0
rx_pop  out  1  one-cycle pop strobe to RX FIFO
tx_full  in  1  TX FIFO full
tx_push  out  1  one-cycle push strobe to TX FIFO
tx_data  out  8  byte to TX FIFO, valid with tx_push
count  in  14  current counter value
btn_run  in  1  debounced one-cycle pulse, toggles run
btn_clear  in  1  debounced one-cycle pulse, clear request
btn_mode  in  1  debounced one-cycle pulse, toggles mode
o_run  out  1  counter enable level
o_clear  out  1  one-cycle counter clear pulse
o_mode  out  1  counter mode level (0 = up, 1 = down)
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE; o_run=0, o_mode=0, o_clear=0, rx_pop=0, tx_push=0, tx_data=0, busy=0. Digit registers and snapshot are cleared.
- Reset mid-ECHO, CONV or REPORT aborts the sequence; no further bytes are pushed.
- States: IDLE, ECHO, CONV, REPORT.
- IDLE, rx_empty=0 at cycle N:
  - rx_pop=1 for exactly cycle N; rx_data latched into cmd_r.
  - count latched into snap; values > CNT_MAX are clamped to CNT_MAX.
  - Next state: ECHO if ECHO_EN=1; else CONV if cmd is CMD_STAT; else IDLE.
- Command action is registered at cycle N+1, independent of echo completion:
  - CMD_RUN: o_run toggles.
  - CMD_CLR: o_clear=1 for cycle N+1 only.
  - CMD_MODE: o_mode toggles.
  - Any other byte: no control action; it is still echoed if ECHO_EN=1.
- Only one byte is popped per pass through IDLE; no pop occurs outside IDLE.
- ECHO:
  - tx_push=1 with tx_data=cmd_r on the first cycle with tx_full=0.
  - The state holds with tx_push=0 while tx_full=1.
  - After the push: CONV if cmd_r=CMD_STAT, else IDLE.
- CONV:
  - Binary-to-BCD conversion of snap by shift-add-3, exactly 14 cycles.
  - Produces d3..d0 (thousands..units), then enters REPORT.
  - snap 0 yields "0000". Leading zeros are always sent.
- REPORT:
  - Pushes six bytes in order: 8'h30+d3, 8'h30+d2, 8'h30+d1, 8'h30+d0, 8'h0D, 8'h0A.
  - One byte per cycle while tx_full=0; stalls in place (byte index held) while tx_full=1.
  - After the 8'h0A push the state returns to IDLE.
- Buttons are accepted in every state, including during reset release cycle+1:
  - btn_run toggles o_run at next edge.
  - btn_mode toggles o_mode at next edge.
  - btn_clear gives a one-cycle o_clear pulse at next edge.
- Simultaneous button and UART command of the same kind in the same cycle: a single toggle / single pulse (OR-merged), not a double toggle.
- The status report reflects count at pop time, not at report time.
- tx_push is never asserted when tx_full=1. rx_pop is never asserted when rx_empty=1.

Test Plan:
- Reset release, push 'd' (8'h64) to RX, TX never full: rx_pop one pulse, o_run 0→1 one cycle later, TX FIFO receives 8'h64. A second 'd' gives o_run 1→0.
- count=1234, send 's': TX FIFO receives 73,31,32,33,34,0D,0A in order. busy high from pop to last push; pop-to-first-digit push latency is ECHO+14 CONV cycles.
- count=16383 (above CNT_MAX), send 's': digits "9999". count=7, send 's': digits "0007".
- Hold tx_full=1 for 20 cycles during REPORT after 2 digits: no push while full, remaining four bytes follow without loss or duplication.
- btn_mode pulse in same cycle as popped 'm': o_mode toggles once. btn_clear during REPORT: o_clear pulses one cycle, report unaffected.
- Assert rst=0 mid-REPORT (after 3 bytes): outputs 0 immediately, no further push after release. Subsequent 'r' gives one o_clear pulse and echo 8'h72.

Source files
------------

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer
//   Sits between the UART RX/TX FIFOs and the 0-9999 counter. Each byte
//   popped from the RX FIFO is echoed to the TX FIFO. The byte may also
//   toggle run or mode, or pulse clear. A status byte sends a report: the
//   count captured at pop time, as four ASCII decimal digits plus CR LF.
//   Debounced button pulses are OR-merged with the UART commands.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   rx_empty, rx_data   RX FIFO status / head byte
//   rx_pop              pop strobe to RX FIFO
//   tx_full             TX FIFO full
//   tx_push, tx_data    push strobe and byte to TX FIFO
//   count               live counter value (14 bits)
//   btn_run/clear/mode  debounced one-cycle button pulses
//   o_run, o_mode       counter enable / direction levels
//   o_clear             one-cycle counter clear pulse
//   busy                high whenever the sequencer is not idle
module uart_cmd_sequencer #(
  parameter bit          ECHO_EN  = 1'b1,
  parameter logic [7:0]  CMD_RUN  = 8'h64,
  parameter logic [7:0]  CMD_CLR  = 8'h72,
  parameter logic [7:0]  CMD_MODE = 8'h6d,
  parameter logic [7:0]  CMD_STAT = 8'h73,
  parameter logic [13:0] CNT_MAX  = 14'd9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  output logic        rx_pop,
  input  logic        tx_full,
  output logic        tx_push,
  output logic [7:0]  tx_data,
  input  logic [13:0] count,
  input  logic        btn_run,
  input  logic        btn_clear,
  input  logic        btn_mode,
  output logic        o_run,
  output logic        o_clear,
  output logic        o_mode,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ECHO   = 2'd1,
    S_CONV   = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [13:0] snap_q, snap_d;   // binary snapshot, shifted out during CONV
  logic [15:0] bcd_q, bcd_d;     // d3..d0 after conversion
  logic [3:0]  step_q, step_d;   // conversion step 0..13
  logic [2:0]  idx_q, idx_d;     // report byte index 0..5
  logic        o_run_q, o_mode_q, o_clear_q;

  logic        pop_s;
  logic        push_s;
  logic        run_tgl_s;
  logic        mode_tgl_s;
  logic        clr_pulse_s;
  logic [29:0] conv_s;
  logic [3:0]  digit_s;
  logic [7:0]  report_byte_s;
  logic [7:0]  tx_data_s;

  // One shift-add-3 step on {bcd, binary}: correct every BCD digit that is
  // 5 or more, then shift the whole vector left by one.
  function automatic logic [29:0] dd_step(input logic [29:0] v);
    logic [29:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
      end else begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4];
      end
    end
    return {t[28:0], 1'b0};
  endfunction

  // The pop and push strobes follow the current FIFO flags in the same cycle.
  // This way a pop never meets an empty RX FIFO and a push never meets a
  // full TX FIFO.
  assign pop_s  = rst & (state_q == S_IDLE) & ~rx_empty;
  assign push_s = ((state_q == S_ECHO) | (state_q == S_REPORT)) & ~tx_full;

  // UART commands and buttons of the same kind merge into one event.
  assign run_tgl_s   = btn_run   | (pop_s & (rx_data == CMD_RUN));
  assign mode_tgl_s  = btn_mode  | (pop_s & (rx_data == CMD_MODE));
  assign clr_pulse_s = btn_clear | (pop_s & (rx_data == CMD_CLR));

  assign conv_s = dd_step({bcd_q, snap_q});

  // Select the BCD digit for the current report position.
  always_comb begin
    digit_s = 4'd0;
    case (idx_q)
      3'd0:    digit_s = bcd_q[15:12];
      3'd1:    digit_s = bcd_q[11:8];
      3'd2:    digit_s = bcd_q[7:4];
      3'd3:    digit_s = bcd_q[3:0];
      default: digit_s = 4'd0;
    endcase
  end

  // Build the report byte: four ASCII digits, then CR, then LF.
  always_comb begin
    report_byte_s = 8'h00;
    case (idx_q)
      3'd0, 3'd1, 3'd2, 3'd3: report_byte_s = 8'h30 + {4'd0, digit_s};
      3'd4:                   report_byte_s = 8'h0D;
      3'd5:                   report_byte_s = 8'h0A;
      default:                report_byte_s = 8'h00;
    endcase
  end

  // Choose the TX byte by state; the bus stays at zero when nothing is sent.
  always_comb begin
    tx_data_s = 8'h00;
    if (state_q == S_ECHO) begin
      tx_data_s = cmd_q;
    end else if (state_q == S_REPORT) begin
      tx_data_s = report_byte_s;
    end else begin
      tx_data_s = 8'h00;
    end
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    snap_d  = snap_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          cmd_d  = rx_data;
          snap_d = (count > CNT_MAX) ? CNT_MAX : count;
          bcd_d  = 16'd0;
          step_d = 4'd0;
          idx_d  = 3'd0;
          if (ECHO_EN) begin
            state_d = S_ECHO;
          end else if (rx_data == CMD_STAT) begin
            state_d = S_CONV;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ECHO: begin
        if (push_s) begin
          state_d = (cmd_q == CMD_STAT) ? S_CONV : S_IDLE;
        end else begin
          state_d = S_ECHO;
        end
      end
      S_CONV: begin
        {bcd_d, snap_d} = conv_s;
        step_d          = step_q + 4'd1;
        if (step_q == 4'd13) begin
          state_d = S_REPORT;
        end else begin
          state_d = S_CONV;
        end
      end
      S_REPORT: begin
        if (push_s) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = S_REPORT;
          end
        end else begin
          state_d = S_REPORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and control-output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= 8'h00;
      snap_q    <= 14'd0;
      bcd_q     <= 16'd0;
      step_q    <= 4'd0;
      idx_q     <= 3'd0;
      o_run_q   <= 1'b0;
      o_mode_q  <= 1'b0;
      o_clear_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      snap_q    <= snap_d;
      bcd_q     <= bcd_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      o_run_q   <= o_run_q ^ run_tgl_s;
      o_mode_q  <= o_mode_q ^ mode_tgl_s;
      o_clear_q <= clr_pulse_s;
    end
  end

  assign rx_pop  = pop_s;
  assign tx_push = push_s;
  assign tx_data = tx_data_s;
  assign o_run   = o_run_q;
  assign o_mode  = o_mode_q;
  assign o_clear = o_clear_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Testbench for uart_cmd_sequencer: array-backed RX FIFO, expected-TX
// scoreboard, control-level reference model and a negedge monitor.
module tb_uart_cmd_sequencer;

  localparam logic [7:0] CMD_RUN  = 8'h64;
  localparam logic [7:0] CMD_CLR  = 8'h72;
  localparam logic [7:0] CMD_MODE = 8'h6d;
  localparam logic [7:0] CMD_STAT = 8'h73;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        rx_pop;
  logic        tx_full = 1'b0;
  logic        tx_push;
  logic [7:0]  tx_data;
  logic [13:0] count = 14'd0;
  logic        btn_run = 1'b0;
  logic        btn_clear = 1'b0;
  logic        btn_mode = 1'b0;
  logic        o_run;
  logic        o_clear;
  logic        o_mode;
  logic        busy;

  // RX FIFO: stimulus writes rx_mem/rx_wr, the model process advances rx_rd.
  logic [7:0] rx_mem [0:63];
  int         rx_wr = 0;
  int         rx_rd = 0;
  assign rx_empty = (rx_wr == rx_rd);
  assign rx_data  = rx_mem[rx_rd[5:0]];

  // Expected TX bytes: stimulus appends, monitor consumes.
  logic [7:0] exp_mem [0:255];
  int         exp_wr = 0;
  int         exp_rd = 0;

  // Reference model of the control outputs.
  logic m_run = 1'b0, m_mode = 1'b0, m_clear = 1'b0;
  logic s_pop = 1'b0, s_brun = 1'b0, s_bclr = 1'b0, s_bmode = 1'b0;
  logic [7:0] s_byte = 8'h00;
  int   cyc = 0;

  // Monitor bookkeeping.
  int   checks = 0;
  int   errors = 0;
  int   pop_cyc = 0;
  int   pushes_since = 0;
  logic [7:0] last_cmd = 8'h00;
  int   tmo_seen = 0;
  logic final_done = 1'b0;

  // Stimulus-owned flags.
  int   timeouts = 0;
  logic lat_en = 1'b0;
  logic rand_en = 1'b0;
  logic final_req = 1'b0;

  uart_cmd_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .rx_empty (rx_empty),
    .rx_data  (rx_data),
    .rx_pop   (rx_pop),
    .tx_full  (tx_full),
    .tx_push  (tx_push),
    .tx_data  (tx_data),
    .count    (count),
    .btn_run  (btn_run),
    .btn_clear(btn_clear),
    .btn_mode (btn_mode),
    .o_run    (o_run),
    .o_clear  (o_clear),
    .o_mode   (o_mode),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies the events sampled at the previous negedge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (!rst) begin
      m_run   = 1'b0;
      m_mode  = 1'b0;
      m_clear = 1'b0;
    end else begin
      m_run   = m_run  ^ (s_brun  | (s_pop && s_byte == CMD_RUN));
      m_mode  = m_mode ^ (s_bmode | (s_pop && s_byte == CMD_MODE));
      m_clear = s_bclr | (s_pop && s_byte == CMD_CLR);
      if (s_pop) rx_rd = rx_rd + 1;
    end
  end

  // Monitor: samples inputs for the model and checks every DUT output.
  always @(negedge clk) begin
    s_pop   = rx_pop;
    s_byte  = rx_data;
    s_brun  = btn_run;
    s_bclr  = btn_clear;
    s_bmode = btn_mode;
    if (!rst) begin
      chk("reset_outputs", {20'd0, o_run, o_mode, o_clear, rx_pop, tx_push, busy, tx_data}, 32'd0);
      exp_rd       = exp_wr;
      pushes_since = 0;
    end else begin
      chk("o_run", {31'd0, o_run}, {31'd0, m_run});
      chk("o_mode", {31'd0, o_mode}, {31'd0, m_mode});
      chk("o_clear", {31'd0, o_clear}, {31'd0, m_clear});
      if (rx_pop) begin
        chk("pop_when_empty", {31'd0, rx_empty}, 32'd0);
        chk("busy_at_pop", {31'd0, busy}, 32'd0);
        pop_cyc      = cyc;
        pushes_since = 0;
        last_cmd     = rx_data;
      end
      if (tx_push) begin
        pushes_since = pushes_since + 1;
        chk("push_when_full", {31'd0, tx_full}, 32'd0);
        chk("busy_at_push", {31'd0, busy}, 32'd1);
        if (exp_rd == exp_wr) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL tx_unexpected actual=%0h required=none t=%0t", tx_data, $time);
        end else begin
          chk("tx_data", {24'd0, tx_data}, {24'd0, exp_mem[exp_rd[7:0]]});
          exp_rd = exp_rd + 1;
        end
        if (lat_en && last_cmd == CMD_STAT && pushes_since == 2)
          chk("first_digit_latency", cyc - pop_cyc, 32'd16);
      end
    end
    if (timeouts != tmo_seen) begin
      chk("wait_timeout", timeouts, tmo_seen);
      tmo_seen = timeouts;
    end
    if (final_req && !final_done) begin
      chk("tx_drained", exp_wr - exp_rd, 32'd0);
      chk("rx_drained", rx_wr - rx_rd, 32'd0);
      final_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_en) begin
      tx_full   = ($urandom_range(0, 3) == 0);
      btn_run   = ($urandom_range(0, 15) == 0);
      btn_clear = ($urandom_range(0, 15) == 0);
      btn_mode  = ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic exp_push(input logic [7:0] b);
    exp_mem[exp_wr[7:0]] = b;
    exp_wr = exp_wr + 1;
  endtask

  // Queue the expected echo/report, then offer the byte and wait for its pop.
  task automatic send(input logic [7:0] b, input logic [2:0] btns);
    int v;
    v = (int'(count) > 9999) ? 9999 : int'(count);
    exp_push(b);
    if (b == CMD_STAT) begin
      exp_push(8'(48 + v / 1000));
      exp_push(8'(48 + (v / 100) % 10));
      exp_push(8'(48 + (v / 10) % 10));
      exp_push(8'(48 + v % 10));
      exp_push(8'h0D);
      exp_push(8'h0A);
    end
    rx_mem[rx_wr[5:0]] = b;
    rx_wr = rx_wr + 1;
    {btn_run, btn_clear, btn_mode} = btns;
    step();
    {btn_run, btn_clear, btn_mode} = 3'b000;
    for (int i = 0; i < 300 && rx_rd != rx_wr; i++) step();
    if (rx_rd != rx_wr) timeouts = timeouts + 1;
    count = 14'($urandom_range(0, 16383));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(exp_rd == exp_wr && !busy && rx_empty) && n < 800) begin
      step();
      n = n + 1;
    end
    if (n >= 800) timeouts = timeouts + 1;
  endtask

  task automatic wait_pushes(input int k);
    int n;
    n = 0;
    while (pushes_since < k && n < 200) begin
      step();
      n = n + 1;
    end
    if (n >= 200) timeouts = timeouts + 1;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 64; i++) rx_mem[i] = 8'h00;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Run toggles on and off, each echoed.
    send(CMD_RUN, 3'b000);
    wait_idle();
    send(CMD_RUN, 3'b000);
    wait_idle();

    // Reports at several counts, including clamp and zero; latency checked.
    lat_en = 1'b1;
    count = 14'd1234;  send(CMD_STAT, 3'b000); wait_idle();
    count = 14'd16383; send(CMD_STAT, 3'b000); wait_idle();
    count = 14'd7;     send(CMD_STAT, 3'b000); wait_idle();
    count = 14'd0;     send(CMD_STAT, 3'b000); wait_idle();
    count = 14'd9999;  send(CMD_STAT, 3'b000); wait_idle();
    count = 14'd10000; send(CMD_STAT, 3'b000); wait_idle();
    lat_en = 1'b0;

    // TX stall after two report digits.
    count = 14'd5678;
    send(CMD_STAT, 3'b000);
    wait_pushes(3);
    tx_full = 1'b1;
    repeat (20) step();
    tx_full = 1'b0;
    wait_idle();

    // Mode button in the same cycle as a popped 'm', then run button + 'd'.
    send(CMD_MODE, 3'b001);
    wait_idle();
    send(CMD_RUN, 3'b100);
    wait_idle();

    // Clear button during a report.
    count = 14'd4096;
    send(CMD_STAT, 3'b000);
    wait_pushes(2);
    btn_clear = 1'b1;
    step();
    btn_clear = 1'b0;
    wait_idle();

    // Reset mid-report; a pending 'r' is held off until release.
    send(CMD_MODE, 3'b000);
    wait_idle();
    count = 14'd4321;
    send(CMD_STAT, 3'b000);
    wait_pushes(4);
    rst = 1'b0;
    rx_mem[rx_wr[5:0]] = CMD_CLR;
    rx_wr = rx_wr + 1;
    repeat (3) step();
    exp_push(CMD_CLR);
    rst = 1'b1;
    step();
    wait_idle();

    // Randomised commands, counts, buttons and TX back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      count = 14'($urandom_range(0, 16383));
      case ($urandom_range(0, 5))
        0: b = CMD_RUN;
        1: b = CMD_CLR;
        2: b = CMD_MODE;
        3, 4: b = CMD_STAT;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b, 3'($urandom_range(0, 7)));
      wait_idle();
    end
    rand_en = 1'b0;
    tx_full = 1'b0;
    {btn_run, btn_clear, btn_mode} = 3'b000;
    step();
    wait_idle();
    repeat (4) step();

    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_done; i++) step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
